frac_baud_tick_gen: RTL and testbench
=====================================

Name: frac_baud_tick_gen

Overview:
Runtime-programmable baud tick generator for the UART datapath. It replaces the fixed mod-M tick counter with a divisor that has integer and fractional parts, a fractional accumulator that dithers the period, and an oversampling phase counter. It produces oversample, mid-bit and bit-boundary ticks for the UART rx/tx FSMs. Divisor updates are shadowed and applied glitch-free on a tick boundary.

Parameters:
CNT_W, 16, width of integer divisor and cycle counter
FRAC_W, 4, width of fractional divisor and accumulator
OVS, 16, oversample ticks per bit (even, >=4)
OVS_W, 4, width of oversample phase counter (clog2(OVS))
DEF_INT, 27, integer divisor after reset
DEF_FRAC, 2, fractional divisor after reset (27+2/16 = 50 MHz / (115200*16))

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
en  in  1  count enable; 0 freezes all state
sync_clr  in  1  restart phase: clears cnt, acc, extra, ovs phase
div_int  in  CNT_W  new integer divisor
div_frac  in  FRAC_W  new fractional divisor
div_load  in  1  capture div_int/div_frac into the pending shadow
s_tick  out  1  oversample tick, 1 cycle wide
mid_tick  out  1  s_tick coinciding with ovs phase OVS/2-1
bit_tick  out  1  s_tick coinciding with ovs phase OVS-1
ovs_phase  out  OVS_W  current oversample phase
cnt  out  CNT_W  current cycle count within interval
cfg_err  out  1  active div_int < 2 (clamped)

Behaviour:
- Reset: cnt=0, acc=0, extra=0, ovs_phase=0, active divisor = DEF_INT/DEF_FRAC, pending flag=0. Outputs: s_tick/mid_tick/bit_tick=0 while reset is high, cfg_err=(DEF_INT<2).
- eff_int = max(active_int, 2). cfg_err=1 when active_int<2.
- limit = eff_int + extra. cnt counts 0..limit-1 and wraps to 0.
- s_tick = en & ~sync_clr & ~reset & (cnt==limit-1). The tick is combinational from registered state. The first tick comes limit cycles after en rises from the cleared state.
- On s_tick: {carry,acc} <= acc + active_frac (FRAC_W+1 bits). extra <= carry. Average period = eff_int + frac/2^FRAC_W.
- On s_tick: ovs_phase increments mod OVS. mid_tick = s_tick & (ovs_phase==OVS/2-1). bit_tick = s_tick & (ovs_phase==OVS-1).
- div_load: captures the inputs into the pending registers and sets the pending flag. A second load before the pending value is applied overwrites it.
- Apply rule: pending is copied to active on the s_tick cycle, or immediately on the next edge if en=0 or sync_clr=1. The new limit is used from the following interval. The in-flight interval is never shortened.
- en=0: cnt, acc, extra, ovs_phase hold. No ticks.
- sync_clr: priority over en. cnt, acc, extra, ovs_phase <= 0. Divisor is kept. No ticks that cycle.
- div_load and sync_clr in the same cycle: the load is applied and the counters are cleared.
- Reset has priority over everything. Reset mid-interval returns to reset values, and pending loads are discarded.
- Arithmetic is unsigned. cnt compare uses CNT_W+1 bits so limit=2^CNT_W cannot overflow.

Decomposition:
- Shared package uart_pkg holds: CNT_W, FRAC_W, OVS defaults; DEF_INT/DEF_FRAC for the 50 MHz/115200 config; and a function for clog2.
- One sub-module, ovs_phase_counter (mod-OVS phase counter with inc/clr inputs and mid/max tick outputs), is instantiated once. Top level holds the divisor shadow, the cycle counter and the accumulator.

Test Plan:
- reset, load 10/0, en=1 -> s_tick every 10 cycles; first tick at cycle 10; bit_tick every 160 cycles; mid_tick on the 8th s_tick; cfg_err=0.
- load 10/8 (FRAC_W=4) -> intervals alternate 10,11,10,11; exactly 16 s_ticks in 168 cycles; acc sequence 8,0,8,0.
- div 10/0 running, pulse div_load with 4/0 when cnt=3 -> current interval still ends at cnt=9; subsequent intervals are 4 cycles; two loads 5 then 6 before the tick -> 6 applied.
- sync_clr asserted on a cycle where cnt==limit-1 -> no s_tick; cnt=0, ovs_phase=0 next cycle; next tick exactly limit cycles later.
- load 1/0 and 0/0 -> cfg_err=1, s_tick period 2; load 3/0 -> cfg_err=0 after apply.
- en=0 for 7 cycles mid-interval at cnt=5 -> cnt holds 5, no ticks; resume, tick after 4 more cycles (limit 10); reset asserted mid-run -> all state to defaults, period 27/28 dither pattern restarts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing constants and helpers for the baud tick generator.
package uart_pkg;

    // Ceiling log2 for constant width derivation; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned UART_CNT_W    = 16;
    localparam int unsigned UART_FRAC_W   = 4;
    localparam int unsigned UART_OVS      = 16;
    localparam int unsigned UART_OVS_W    = clog2(UART_OVS);
    // 50 MHz / (115200 * 16) = 27.127 -> 27 + 2/16
    localparam int unsigned UART_DEF_INT  = 27;
    localparam int unsigned UART_DEF_FRAC = 2;

endpackage

// File: rtl/ovs_phase_counter.sv
// Mod-OVS oversample phase counter with mid-bit and last-phase decodes.
module ovs_phase_counter #(
    parameter int unsigned OVS   = 16,
    parameter int unsigned OVS_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [OVS_W-1:0] phase_o,
    output logic             mid_o,
    output logic             max_o
);

    localparam logic [OVS_W-1:0] PH_MID = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0] PH_MAX = OVS_W'(OVS - 1);

    logic [OVS_W-1:0] phase_q;
    logic [OVS_W-1:0] phase_d;

    // Next phase: clear wins, otherwise advance and wrap at OVS-1.
    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (inc_i) begin
            phase_d = (phase_q == PH_MAX) ? '0 : phase_q + OVS_W'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign mid_o   = (phase_q == PH_MID);
    assign max_o   = (phase_q == PH_MAX);

endmodule

// File: rtl/frac_baud_tick_gen.sv
// Fractional-divisor baud tick generator: shadowed divisor, cycle counter,
// dither accumulator and oversample phase for the UART rx/tx FSMs.
module frac_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W    = UART_CNT_W,
    parameter int unsigned FRAC_W   = UART_FRAC_W,
    parameter int unsigned OVS      = UART_OVS,
    parameter int unsigned OVS_W    = UART_OVS_W,
    parameter int unsigned DEF_INT  = UART_DEF_INT,
    parameter int unsigned DEF_FRAC = UART_DEF_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync_clr,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              s_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [OVS_W-1:0]  ovs_phase,
    output logic [CNT_W-1:0]  cnt,
    output logic              cfg_err
);

    localparam int unsigned LIM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0]  RST_INT  = CNT_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_FRAC);
    localparam logic [CNT_W-1:0]  MIN_INT  = CNT_W'(2);

    logic [CNT_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [CNT_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_q,     pend_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [FRAC_W-1:0] acc_q,      acc_d;
    logic              extra_q,    extra_d;

    logic [CNT_W-1:0]  eff_int;
    logic [LIM_W-1:0]  last_cnt;
    logic [FRAC_W:0]   acc_sum;
    logic              tick;
    logic              pend_v;
    logic [CNT_W-1:0]  pend_int_n;
    logic [FRAC_W-1:0] pend_frac_n;
    logic              apply;
    logic              ph_mid;
    logic              ph_max;

    // Interval end detect; >= recovers cleanly if the divisor was lowered while frozen.
    always_comb begin
        eff_int  = (act_int_q < MIN_INT) ? MIN_INT : act_int_q;
        last_cnt = {1'b0, eff_int} + LIM_W'(extra_q) - LIM_W'(1);
        tick     = en & ~sync_clr & ~reset & ({1'b0, cnt_q} >= last_cnt);
    end

    // Cycle counter and fractional accumulator; the carry stretches the next interval.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        extra_d = extra_q;
        acc_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
        if (sync_clr) begin
            cnt_d   = '0;
            acc_d   = '0;
            extra_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            acc_d   = acc_sum[FRAC_W-1:0];
            extra_d = acc_sum[FRAC_W];
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divisor shadow: a load (or a held pending value) goes live at a tick or while idle/clearing.
    always_comb begin
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_v      = div_load | pend_q;
        pend_int_n  = div_load ? div_int  : pend_int_q;
        pend_frac_n = div_load ? div_frac : pend_frac_q;
        apply       = pend_v & (tick | ~en | sync_clr);
        pend_int_d  = pend_int_n;
        pend_frac_d = pend_frac_n;
        pend_d      = pend_v;
        if (apply) begin
            act_int_d  = pend_int_n;
            act_frac_d = pend_frac_n;
            pend_d     = 1'b0;
        end
    end

    // State registers; reset restores the default divisor and drops any pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_int_q   <= RST_INT;
            act_frac_q  <= RST_FRAC;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            extra_q     <= 1'b0;
        end else begin
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            extra_q     <= extra_d;
        end
    end

    ovs_phase_counter #(
        .OVS   (OVS),
        .OVS_W (OVS_W)
    ) u_ovs (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (tick),
        .clr_i   (sync_clr),
        .phase_o (ovs_phase),
        .mid_o   (ph_mid),
        .max_o   (ph_max)
    );

    assign s_tick   = tick;
    assign mid_tick = tick & ph_mid;
    assign bit_tick = tick & ph_max;
    assign cnt      = cnt_q;
    assign cfg_err  = (act_int_q < MIN_INT);

endmodule

// File: tb/tb_frac_baud_tick_gen.sv
// Scoreboard bench for frac_baud_tick_gen: stimulus queues expected tick cycles,
// a negedge monitor pops and compares every s_tick.
module tb_frac_baud_tick_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic        sync_clr;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        s_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic [3:0]  ovs_phase;
    logic [15:0] cnt;
    logic        cfg_err;

    frac_baud_tick_gen dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync_clr  (sync_clr),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .div_load  (div_load),
        .s_tick    (s_tick),
        .mid_tick  (mid_tick),
        .bit_tick  (bit_tick),
        .ovs_phase (ovs_phase),
        .cnt       (cnt),
        .cfg_err   (cfg_err)
    );

    typedef struct {
        int c;
        bit m;
        bit b;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tick_n = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   c0;
    int   t;

    int iv2[16] = '{10, 10, 11, 10, 11, 10, 11, 10, 11, 10, 11, 10, 11, 10, 11, 10};
    int iv3[7]  = '{9, 13, 17, 21, 25, 31, 37};
    int iv6[10] = '{27, 27, 27, 27, 27, 27, 27, 27, 28, 27};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every s_tick must match the head of the expected queue.
    always @(negedge clk) begin
        if (s_tick) begin
            n_assert++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL tick: unexpected s_tick at cycle %0d", cyc);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.c != cyc || mid_tick != mon_e.m || bit_tick != mon_e.b) begin
                    n_fail++;
                    $display("FAIL tick: got cycle %0d mid %0d bit %0d, expected cycle %0d mid %0d bit %0d",
                             cyc, mid_tick, bit_tick, mon_e.c, mon_e.m, mon_e.b);
                end
            end
        end else begin
            if (q.size() != 0 && q[0].c <= cyc) begin
                n_assert++;
                n_fail++;
                $display("FAIL tick: missing s_tick, expected at cycle %0d, now %0d", q[0].c, cyc);
                void'(q.pop_front());
            end
            if (mid_tick || bit_tick) begin
                n_assert++;
                n_fail++;
                $display("FAIL qual: mid %0d bit %0d without s_tick at cycle %0d", mid_tick, bit_tick, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_tick(input int c);
        exp_t e;
        e.c = c;
        e.m = ((tick_n % 16) == 7);
        e.b = ((tick_n % 16) == 15);
        q.push_back(e);
        tick_n++;
    endtask

    // Load a divisor with sync_clr, then enable; c0 is the first enabled cycle.
    task automatic restart(input int di, input int df);
        en       = 1'b0;
        sync_clr = 1'b1;
        div_load = 1'b1;
        div_int  = 16'(di);
        div_frac = 4'(df);
        step();
        sync_clr = 1'b0;
        div_load = 1'b0;
        en       = 1'b1;
        tick_n   = 0;
        c0       = cyc;
    endtask

    task automatic load(input int di, input int df);
        div_load = 1'b1;
        div_int  = 16'(di);
        div_frac = 4'(df);
        step();
        div_load = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        sync_clr = 1'b0;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;
        repeat (3) step();
        check("rst_cnt", int'(cnt), 0);
        check("rst_phase", int'(ovs_phase), 0);
        check("rst_stick", int'(s_tick), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        reset = 1'b0;
        step();

        // 10/0: period 10, mid on 8th tick, bit every 160 cycles.
        restart(10, 0);
        check("s1_cfg_err", int'(cfg_err), 0);
        for (int k = 0; k < 32; k++) expect_tick(c0 + 9 + 10 * k);
        goto(c0 + 15);
        check("s1_cnt", int'(cnt), 5);
        check("s1_phase", int'(ovs_phase), 1);
        goto(c0 + 322);

        // 10/8: dithered 10/11 intervals, 16 ticks within 168 cycles.
        restart(10, 8);
        t = c0 - 1;
        for (int k = 0; k < 16; k++) begin
            t += iv2[k];
            expect_tick(t);
        end
        goto(c0 + 168);
        check("s2_pending", q.size(), 0);

        // Load while in flight: current interval completes, then shorter; last of two loads wins.
        restart(10, 0);
        for (int k = 0; k < 7; k++) expect_tick(c0 + iv3[k]);
        goto(c0 + 3);
        check("s3_cnt_at_load", int'(cnt), 3);
        load(4, 0);
        goto(c0 + 22);
        load(5, 0);
        load(6, 0);
        goto(c0 + 40);

        // sync_clr on the terminal count suppresses the tick and restarts the phase.
        restart(10, 0);
        expect_tick(c0 + 9);
        goto(c0 + 19);
        check("s4_cnt_last", int'(cnt), 9);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        tick_n   = 0;
        check("s4_cnt_clr", int'(cnt), 0);
        check("s4_phase_clr", int'(ovs_phase), 0);
        expect_tick(c0 + 29);
        goto(c0 + 31);

        // Divisor clamp: 1 and 0 run at period 2 with cfg_err, 3 clears it once applied.
        restart(1, 0);
        check("s5_cfg_err_1", int'(cfg_err), 1);
        expect_tick(c0 + 1);
        expect_tick(c0 + 3);
        expect_tick(c0 + 5);
        goto(c0 + 6);
        restart(0, 0);
        check("s5_cfg_err_0", int'(cfg_err), 1);
        expect_tick(c0 + 1);
        expect_tick(c0 + 3);
        expect_tick(c0 + 6);
        expect_tick(c0 + 9);
        goto(c0 + 2);
        load(3, 0);
        check("s5_cfg_err_pend", int'(cfg_err), 1);
        step();
        check("s5_cfg_err_3", int'(cfg_err), 0);
        goto(c0 + 11);

        // Freeze mid-interval, resume, then reset mid-run with a load pending.
        restart(10, 0);
        expect_tick(c0 + 16);
        expect_tick(c0 + 26);
        goto(c0 + 5);
        check("s6_cnt_frz", int'(cnt), 5);
        en = 1'b0;
        goto(c0 + 11);
        check("s6_cnt_hold", int'(cnt), 5);
        goto(c0 + 12);
        en = 1'b1;
        goto(c0 + 28);
        load(4, 0);
        goto(c0 + 30);
        check("s6_cnt_pre_rst", int'(cnt), 3);
        reset = 1'b1;
        step();
        step();
        reset  = 1'b0;
        tick_n = 0;
        check("s6_rst_cnt", int'(cnt), 0);
        check("s6_rst_phase", int'(ovs_phase), 0);
        check("s6_rst_cfg_err", int'(cfg_err), 0);
        t = cyc - 1;
        for (int k = 0; k < 10; k++) begin
            t += iv6[k];
            expect_tick(t);
        end
        goto(t + 3);
        check("end_pending", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
